mem_port_arbiter: RTL and testbench

- Sequences and shares a single-port synchronous 16x8 scratch memory between two requesters.
- After reset, a clear state machine zero-fills every address. It then grants one access per cycle using round-robin arbitration and returns read data one cycle later.
- Sits between the memory array and its client logic, in the same clock domain.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the two-port scratch-memory arbiter.
//   state_t    : sequencing state (CLEAR zero-fills, RUN arbitrates).
//   NUM_REQ    : number of requesters sharing the memory port.
//   CONFLICT_W : width of the optional conflict counter (MEM_ARB_STATS_EN).
package mem_arb_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int NUM_REQ    = 2;
  localparam int CONFLICT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter: combinational grant plus the pointer register.
//   Ports:
//     clk     in   clock, pointer updates on rising edge
//     rst     in   synchronous active-high reset (pointer -> 0)
//     en      in   arbitration enable; no grant while low
//     req     in   [1:0] request vector
//     grant   out  [1:0] one-hot (or zero) grant vector
//     winner  out  index of the granted requester (valid when granted=1)
//     granted out  high when any grant is issued this cycle
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       winner,
  output logic       granted
);

  logic rr_ptr;

  // A lone requester always wins; on contention the pointer picks the winner.
  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin
          grant  = 2'b01;
          winner = 1'b0;
        end
        2'b10: begin
          grant  = 2'b10;
          winner = 1'b1;
        end
        2'b11: begin
          winner = rr_ptr;
          grant  = rr_ptr ? 2'b10 : 2'b01;
        end
        default: begin
          grant  = 2'b00;
          winner = 1'b0;
        end
      endcase
    end
  end

  assign granted = |grant;

  // After any grant, priority moves to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (granted) begin
      rr_ptr <= ~winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-port synchronous scratch memory between two requesters.
//   After reset it zero-fills every address (CLEAR), then grants one access per
//   cycle with round-robin arbitration (RUN). Every granted access produces a
//   response one cycle later carrying the memory's registered read data
//   (pre-write contents for a write).
//   Optional feature macro: MEM_ARB_STATS_EN adds output conflict_cnt, a
//   saturating count of RUN cycles in which both requesters were valid.
//   Ports:
//     clk, rst                 clock / synchronous active-high reset
//     req_valid/req_ready      per-requester handshake (bit i = requester i)
//     req_we/req_addr/req_wdata per-requester command, packed by requester
//     rsp_valid/rsp_rdata      one-cycle response pulse and its data
//     mem_addr/mem_wr/mem_wdata combinational memory command
//     mem_rdata                registered memory read data
//     conflict_cnt             (MEM_ARB_STATS_EN only) contention counter
//     init_done                high once the clear sequence has finished
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
`ifdef MEM_ARB_STATS_EN
  output logic [CONFLICT_W-1:0]     conflict_cnt,
`endif
  output logic                      init_done
);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   rdata_hold;
  logic [NUM_REQ-1:0]  grant;
  logic                winner;
  logic                granted;
  logic                arb_en;

  // Arbitration is only live in RUN and is suppressed combinationally by rst.
  assign arb_en = (state == RUN) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req     (req_valid),
    .grant   (grant),
    .winner  (winner),
    .granted (granted)
  );

  assign req_ready = grant;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next state and memory command. CLEAR walks clr_cnt over every address
  // writing zero; the last address doubles as the hand-off to RUN.
  always_comb begin
    state_next = state;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      case (state)
        CLEAR: begin
          mem_wr   = 1'b1;
          mem_addr = clr_cnt;
          if (&clr_cnt) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (granted) begin
            mem_wr    = winner ? req_we[1] : req_we[0];
            mem_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            mem_wdata = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          end
        end
        default: begin
          state_next = CLEAR;
        end
      endcase
    end
  end

  // Clear counter, init flag and the one-stage response pipeline. The memory
  // already registers its read data, so only the winner (as a one-hot) is
  // delayed; the data path is held only to keep rsp_rdata stable between
  // responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt    <= '0;
      init_done  <= 1'b0;
      rsp_valid  <= '0;
      rdata_hold <= '0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (state_next == RUN) begin
          init_done <= 1'b1;
        end
      end
      rsp_valid <= grant;
      if (|rsp_valid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  assign rsp_rdata = (|rsp_valid) ? mem_rdata : rdata_hold;

`ifdef MEM_ARB_STATS_EN
  // Contention counter: counts RUN cycles with both requesters valid and
  // sticks at its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if ((state == RUN) && (&req_valid) && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Provides a behavioural 16x8
//   synchronous memory and a reference model kept as plain arrays: expected
//   memory contents, the most recent winner, the pending response and the
//   conflict count. Compile with MEM_ARB_STATS_EN to exercise conflict_cnt.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [3:0]  mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        init_done;
`ifdef MEM_ARB_STATS_EN
  logic [7:0]  conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .conflict_cnt (conflict_cnt),
`endif
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Behavioural memory: registered read, read-before-write. While scramble is
  // high it fills itself with garbage so the clear sequence has work to do.
  logic [7:0] mem_arr [16];
  logic       scramble = 1'b0;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 8'($urandom);
    end else begin
      mem_rdata <= mem_arr[mem_addr];
      if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] ref_mem [16];
  int         ref_last;
  int         ref_conf;
  logic [1:0] exp_rsp_valid;
  logic [7:0] exp_rsp_data;
  int         win;
  logic [1:0] exp_ready;
  logic       exp_wr;
  logic [3:0] exp_addr;
  logic [7:0] exp_wdata;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_last      = 1;
    ref_conf      = 0;
    exp_rsp_valid = 2'b00;
    exp_rsp_data  = 8'h00;
  endtask

  // Whoever did not win the previous grant wins a tie.
  task automatic model_eval();
    win       = -1;
    exp_ready = 2'b00;
    exp_wr    = 1'b0;
    exp_addr  = 4'h0;
    exp_wdata = 8'h00;
    if (req_valid == 2'b11)  win = 1 - ref_last;
    else if (req_valid[0])   win = 0;
    else if (req_valid[1])   win = 1;
    if (win >= 0) begin
      exp_ready = (win == 0) ? 2'b01 : 2'b10;
      exp_wr    = req_we[win];
      exp_addr  = req_addr[win*4 +: 4];
      exp_wdata = req_wdata[win*8 +: 8];
    end
  endtask

  task automatic model_commit();
    model_eval();
    if (win >= 0) begin
      exp_rsp_valid = exp_ready;
      exp_rsp_data  = ref_mem[exp_addr];
      if (exp_wr) ref_mem[exp_addr] = exp_wdata;
      ref_last = win;
    end else begin
      exp_rsp_valid = 2'b00;
    end
    if (req_valid == 2'b11 && ref_conf < 255) ref_conf++;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Advance one RUN cycle: update the model with this cycle's handshake.
  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00);
    rst = 1'b1;
    scramble = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_ready got %b want 00", req_ready); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mem_wr got %b want 0", mem_wr); end
    n_cmp++; if (mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_mem_cmd got %h/%h want 0/00", mem_addr, mem_wdata); end
    @(posedge clk);
    #1;
    scramble = 1'b0;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_rsp_valid got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_rsp_rdata got %h want 00", rsp_rdata); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_init_done got %b want 0", init_done); end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b1 || mem_addr !== 4'(k) || mem_wdata !== 8'h00) begin
        n_bad++; $display("[TB] FAIL clear_cmd cycle %0d got wr=%b addr=%h wdata=%h want 1/%h/00", k, mem_wr, mem_addr, mem_wdata, 4'(k));
      end
      n_cmp++; if (req_ready !== 2'b00 || init_done !== 1'b0) begin
        n_bad++; $display("[TB] FAIL clear_hold cycle %0d got ready=%b init=%b want 00/0", k, req_ready, init_done);
      end
      @(posedge clk);
      #1;
    end
    // Requests held through CLEAR are granted as soon as RUN starts.
    @(negedge clk);
    model_eval();
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("[TB] FAIL init_done got %b want 1", init_done); end
    n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL first_grant got %b want %b", req_ready, exp_ready); end
    tick();
  endtask

  task automatic test_write_read();
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    @(negedge clk);
    model_eval();
    n_cmp++; if (rsp_valid !== exp_rsp_valid) begin n_bad++; $display("[TB] FAIL held_rsp got %b want %b", rsp_valid, exp_rsp_valid); end
    n_cmp++; if (req_ready !== 2'b01 || mem_wr !== 1'b1 || mem_addr !== 4'd3 || mem_wdata !== 8'hA5) begin
      n_bad++; $display("[TB] FAIL wr_cmd got ready=%b wr=%b addr=%h data=%h want 01/1/3/a5", req_ready, mem_wr, mem_addr, mem_wdata);
    end
    tick();
    drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h00) begin n_bad++; $display("[TB] FAIL wr_rsp got %b/%h want 01/00", rsp_valid, rsp_rdata); end
    n_cmp++; if (req_ready !== 2'b10 || mem_wr !== 1'b0 || mem_addr !== 4'd3) begin
      n_bad++; $display("[TB] FAIL rd_cmd got ready=%b wr=%b addr=%h want 10/0/3", req_ready, mem_wr, mem_addr);
    end
    tick();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5) begin n_bad++; $display("[TB] FAIL rd_rsp got %b/%h want 10/a5", rsp_valid, rsp_rdata); end
    n_cmp++; if (req_ready !== 2'b00 || mem_wr !== 1'b0 || mem_addr !== 4'd0) begin
      n_bad++; $display("[TB] FAIL idle_cmd got ready=%b wr=%b addr=%h want 00/0/0", req_ready, mem_wr, mem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_rdata !== 8'hA5) begin n_bad++; $display("[TB] FAIL rsp_hold got %b/%h want 00/a5", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      @(negedge clk);
      model_eval();
      want = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++; if (req_ready !== want || req_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL alt_grant %0d got %b want %b", i, req_ready, want); end
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== exp_rsp_valid || rsp_rdata !== exp_rsp_data) begin
          n_bad++; $display("[TB] FAIL alt_rsp %0d got %b/%h want %b/%h", i, rsp_valid, rsp_rdata, exp_rsp_valid, exp_rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_single_requester();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(2'b10, 2'b00, 4'd0, 4'(i + 8), 8'h00, 8'h00);
      else       drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      @(negedge clk);
      n_cmp++; if (req_ready !== ((i < 3) ? 2'b10 : 2'b00)) begin n_bad++; $display("[TB] FAIL single_grant %0d got %b", i, req_ready); end
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== exp_rsp_data) begin
          n_bad++; $display("[TB] FAIL single_rsp %0d got %b/%h want 10/%h", i, rsp_valid, rsp_rdata, exp_rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      model_eval();
      n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL rand_ready %0d got %b want %b", i, req_ready, exp_ready); end
      n_cmp++; if (mem_wr !== exp_wr || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
        n_bad++; $display("[TB] FAIL rand_mem %0d got %b/%h/%h want %b/%h/%h", i, mem_wr, mem_addr, mem_wdata, exp_wr, exp_addr, exp_wdata);
      end
      n_cmp++; if (rsp_valid !== exp_rsp_valid || rsp_rdata !== exp_rsp_data) begin
        n_bad++; $display("[TB] FAIL rand_rsp %0d got %b/%h want %b/%h", i, rsp_valid, rsp_rdata, exp_rsp_valid, exp_rsp_data);
      end
      tick();
    end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 300; i++) begin
      drive(2'b11, 2'b00, 4'($urandom), 4'($urandom), 8'h00, 8'h00);
      @(negedge clk);
      model_eval();
      n_cmp++; if (conflict_cnt !== 8'(ref_conf) || req_ready !== exp_ready) begin
        n_bad++; $display("[TB] FAIL stats %0d got cnt=%0d ready=%b want %0d/%b", i, conflict_cnt, req_ready, ref_conf, exp_ready);
      end
      tick();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (conflict_cnt !== 8'd255) begin n_bad++; $display("[TB] FAIL stats_sat got %0d want 255", conflict_cnt); end
    tick();
  endtask
`endif

  task automatic test_reset_midop();
    drive(2'b01, 2'b01, 4'd7, 4'd0, 8'h5A, 8'h00);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL mid_wr_grant got %b want 01", req_ready); end
    tick();
    drive(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("[TB] FAIL mid_rd_grant got %b want 10", req_ready); end
    tick();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b00 || rsp_rdata !== 8'h00) begin n_bad++; $display("[TB] FAIL mid_rsp_drop %0d got %b/%h want 00/00", k, rsp_valid, rsp_rdata); end
      n_cmp++; if (mem_wr !== 1'b1 || mem_addr !== 4'(k)) begin n_bad++; $display("[TB] FAIL mid_clear %0d got %b/%h want 1/%h", k, mem_wr, mem_addr, 4'(k)); end
      @(posedge clk);
      #1;
    end
    drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (init_done !== 1'b1 || req_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL mid_rerun got init=%b ready=%b want 1/01", init_done, req_ready); end
    tick();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h00) begin n_bad++; $display("[TB] FAIL mid_readback got %b/%h want 01/00", rsp_valid, rsp_rdata); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    model_reset();
    #1;
    test_reset();
    test_write_read();
    test_alternate();
    test_single_requester();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
